// File: rtl/cheby_pkg.sv
// Shared constants for the BF16 exp-evaluator requester: FSM encodings, data width, BF16 literals.
package cheby_pkg;
  localparam int CHEBY_W = 16;

  localparam logic [15:0] BF16_ONE  = 16'h3F80;
  localparam logic [15:0] BF16_ZERO = 16'h0000;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;
endpackage

// File: rtl/cheby_fifo.sv
// Synchronous FIFO, W x DEPTH (DEPTH power of 2). Head is read straight from storage,
// so a push becomes visible on pop_data/empty one cycle later.
module cheby_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  // push while full is legal only alongside a pop that frees the slot
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

  assign pop_data = mem[rptr];
  assign full     = (cnt == DEPTH_C);
  assign empty    = (cnt == '0);
  assign count    = cnt;
endmodule

// File: rtl/cheby_bf16_requester.sv
// Requester between host operand/result streams and one BF16 exp evaluator, in-order, credit-based.
// Optional watchdog on evaluator replies is built when CHEBY_REQ_TIMEOUT_EN is defined.
import cheby_pkg::*;

module cheby_bf16_requester #(
  parameter int W       = CHEBY_W,
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 1,
  parameter int LEN_W   = 16,
  parameter int TMO     = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_start,
  input  logic [LEN_W-1:0] job_len,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [W-1:0]     op_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [W-1:0]     res_data,
  output logic             ev_in_valid,
  input  logic             ev_in_ready,
  output logic [W-1:0]     ev_in_data,
  input  logic             ev_out_valid,
  output logic             ev_out_ready,
  input  logic [W-1:0]     ev_out_data
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] MAX_C   = CW'(MAX_OUT);
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);

  logic [1:0]       state;
  logic [LEN_W-1:0] len_q, accepted, issued, returned;
  logic [CW-1:0]    outstanding, res_count, op_count;
  logic [CW:0]      credit_sum;
  logic             op_full, op_empty, res_full, res_empty;
  logic             op_push, issue, ret, res_pop, last_issue, wd_trip;

  assign op_push = op_valid && op_ready;
  assign issue   = ev_in_valid && ev_in_ready;
  assign ret     = ev_out_valid && ev_out_ready;
  assign res_pop = res_valid && res_ready;

  cheby_fifo #(.W(W), .DEPTH(DEPTH)) u_op_fifo (
    .clk(clk), .rst(rst), .flush(wd_trip),
    .push(op_push), .push_data(op_data),
    .pop(issue), .pop_data(ev_in_data),
    .full(op_full), .empty(op_empty), .count(op_count)
  );

  cheby_fifo #(.W(W), .DEPTH(DEPTH)) u_res_fifo (
    .clk(clk), .rst(rst), .flush(1'b0),
    .push(ret), .push_data(ev_out_data),
    .pop(res_pop), .pop_data(res_data),
    .full(res_full), .empty(res_empty), .count(res_count)
  );

  logic op_count_unused;
  assign op_count_unused = ^op_count;

  // every request in flight owns a result slot, so a return can never be refused
  assign credit_sum   = {1'b0, outstanding} + {1'b0, res_count};
  assign busy         = (state != ST_IDLE);
  assign done         = (state == ST_DONE);
  assign op_ready     = (state == ST_RUN) && !op_full && (accepted < len_q);
  assign ev_in_valid  = (state == ST_RUN) && !op_empty && (outstanding < MAX_C) &&
                        (credit_sum < DEPTH_C);
  assign ev_out_ready = busy && !res_full;
  assign res_valid    = !res_empty;
  assign last_issue   = (issued == len_q) || (issue && (issued + 1'b1 == len_q));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      len_q       <= '0;
      accepted    <= '0;
      issued      <= '0;
      returned    <= '0;
      outstanding <= '0;
    end else begin
      if (op_push) accepted <= accepted + 1'b1;
      if (issue)   issued   <= issued + 1'b1;
      if (ret)     returned <= returned + 1'b1;
      case ({issue, ret})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: ;
      endcase

      case (state)
        ST_IDLE: if (job_start) begin
          len_q    <= job_len;
          accepted <= '0;
          issued   <= '0;
          returned <= '0;
          state    <= (job_len == '0) ? ST_DONE : ST_RUN;
        end
        ST_RUN:   if (last_issue) state <= ST_DRAIN;
        ST_DRAIN: if (returned == len_q) state <= ST_DONE;
        default:  state <= ST_IDLE;
      endcase

      // an evaluator that stops answering aborts the job
      if (wd_trip) begin
        state       <= ST_DONE;
        outstanding <= '0;
      end
    end
  end

`ifdef CHEBY_REQ_TIMEOUT_EN
  localparam int TW = $clog2(TMO + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

  logic [TW-1:0] wd_cnt;
  logic          err_q;

  assign wd_trip = (outstanding != '0) && !ret && (wd_cnt == TMO_LAST);
  assign err     = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (outstanding == '0 || ret || wd_trip) wd_cnt <= '0;
      else                                     wd_cnt <= wd_cnt + 1'b1;
      if (wd_trip)                               err_q <= 1'b1;
      else if (state == ST_IDLE && job_start)    err_q <= 1'b0;
    end
  end
`else
  logic tmo_unused;
  assign tmo_unused = (TMO != 0);
  assign wd_trip    = 1'b0;
  assign err        = 1'b0;
`endif
endmodule

// File: tb/tb_cheby_bf16_requester.sv
// Directed bench for cheby_bf16_requester: evaluator model replies data+1, queue scoreboard
// checks every handshake per cycle; literal expectations pin each scenario.
import cheby_pkg::*;

module tb_cheby_bf16_requester;
  localparam int W = 16, DEPTH = 4, MAX_OUT = 1, LEN_W = 16, TMO = 16;

  logic             clk, rst;
  logic             job_start;
  logic [LEN_W-1:0] job_len;
  logic             busy, done, err;
  logic             op_valid, op_ready;
  logic [W-1:0]     op_data;
  logic             res_valid, res_ready;
  logic [W-1:0]     res_data;
  logic             ev_in_valid, ev_in_ready;
  logic [W-1:0]     ev_in_data;
  logic             ev_out_valid, ev_out_ready;
  logic [W-1:0]     ev_out_data;

  cheby_bf16_requester #(.W(W), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .LEN_W(LEN_W), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .job_start(job_start), .job_len(job_len),
    .busy(busy), .done(done), .err(err),
    .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .ev_in_valid(ev_in_valid), .ev_in_ready(ev_in_ready), .ev_in_data(ev_in_data),
    .ev_out_valid(ev_out_valid), .ev_out_ready(ev_out_ready), .ev_out_data(ev_out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- model state ----------------
  logic [W-1:0] host_q[$];   // operands the host still offers
  logic [W-1:0] iss_q[$];    // accepted operands, in expected issue order
  logic [W-1:0] res_q[$];    // expected results, in order
  logic [W-1:0] got_q[$];    // results delivered to host
  int  acc_cnt, iss_cnt, ret_cnt, pop_cnt, done_cnt, occ, cur_len, cyc, last_iss_cyc, ncyc;
  bit  saw_ev_in, saw_op_ready, ev_mute, ev_flush;
  int  ev_lat;

  typedef struct { logic [W-1:0] d; int due; } ev_t;
  ev_t ev_q[$];

  // evaluator: replies operand+1, ev_lat cycles after the request
  initial begin
    ev_t e, t;
    ev_out_valid = 1'b0; ev_out_data = '0; ev_in_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || ev_flush) ev_q.delete();
      else begin
        if (ev_out_valid && ev_out_ready) t = ev_q.pop_front();
        if (ev_in_valid && ev_in_ready) begin
          e.d = ev_in_data + 16'h1; e.due = cyc + ev_lat; ev_q.push_back(e);
        end
      end
      @(posedge clk); #1;
      cyc++;
      ev_in_ready  = (cyc % 3) != 0;
      ev_out_valid = !ev_mute && ev_q.size() > 0 && ev_q[0].due <= cyc;
      ev_out_data  = (ev_q.size() > 0) ? ev_q[0].d : '0;
    end
  end

  // host operand source
  initial begin
    logic [W-1:0] t;
    op_valid = 1'b0; op_data = '0;
    forever begin
      @(negedge clk);
      if (!rst && op_valid && op_ready) t = host_q.pop_front();
      @(posedge clk); #1;
      op_valid = host_q.size() > 0;
      op_data  = (host_q.size() > 0) ? host_q[0] : '0;
    end
  end

  // compare process: checks every cycle against the queue model
  initial begin
    logic         p_evv, p_evf, p_rv, p_rf, p_rst;
    logic [W-1:0] p_evd, p_rd, x;
    p_evv = 0; p_evf = 0; p_rv = 0; p_rf = 0; p_rst = 1; p_evd = '0; p_rd = '0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (rst) begin
        iss_q.delete(); res_q.delete(); occ = 0;
      end else begin
        if (!p_rst) begin
          if (p_evv && !p_evf) chk("ev_in_hold", {ev_in_valid, ev_in_data}, {1'b1, p_evd});
          if (p_rv && !p_rf)   chk("res_hold", {res_valid, res_data}, {1'b1, p_rd});
        end
        chk("res_valid_model", res_valid, occ > 0);
        chk("op_ready_len", op_ready && (acc_cnt >= cur_len), 0);
`ifndef CHEBY_REQ_TIMEOUT_EN
        chk("err_tied", err, 0);
`endif
        if (op_valid && op_ready) begin acc_cnt++; iss_q.push_back(op_data); end
        if (ev_in_valid && ev_in_ready) begin
          iss_cnt++; last_iss_cyc = ncyc;
          if (iss_q.size() == 0) chk("ev_in_unexpected", 1, 0);
          else begin x = iss_q.pop_front(); chk("ev_in_data", ev_in_data, x); res_q.push_back(x + 16'h1); end
        end
        if (ev_out_valid && ev_out_ready) begin ret_cnt++; occ++; end
        if (res_valid && res_ready) begin
          pop_cnt++; occ--; got_q.push_back(res_data);
          if (res_q.size() == 0) chk("res_unexpected", 1, 0);
          else begin x = res_q.pop_front(); chk("res_data", res_data, x); end
        end
        chk("outstanding_le_max", (iss_cnt - ret_cnt) <= MAX_OUT, 1);
        chk("res_occ_le_depth", occ <= DEPTH, 1);
        if (done) done_cnt++;
        if (ev_in_valid) saw_ev_in = 1;
        if (op_ready) saw_op_ready = 1;
      end
      p_rst = rst;
      p_evv = ev_in_valid; p_evd = ev_in_data; p_evf = ev_in_valid && ev_in_ready;
      p_rv  = res_valid;   p_rd  = res_data;   p_rf  = res_valid && res_ready;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_job(input int len);
    cur_len = len; acc_cnt = 0; iss_cnt = 0; ret_cnt = 0;
    job_start = 1'b1; job_len = LEN_W'(len);
    @(posedge clk); #1;
    job_start = 1'b0;
  endtask

  // returns on the negedge where done is seen; lat counts negedges since the call
  task automatic wait_done(input int budget, output int lat);
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (done) begin lat = i; break; end
    end
    if (lat < 0) chk("done_timeout", 0, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int lat, d0, p0;
    rst = 1'b1; job_start = 1'b0; job_len = '0; res_ready = 1'b0;
    ev_lat = 4; ev_mute = 0; ev_flush = 0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {busy, done, err, res_valid, ev_in_valid, op_ready, ev_out_ready}, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // T1: three operands, results arrive in order
    res_ready = 1'b1; got_q.delete(); d0 = done_cnt;
    host_q.push_back(BF16_ONE); host_q.push_back(16'h4000); host_q.push_back(16'h4040);
    start_job(3);
    wait_done(200, lat);
    chk("t1_busy_at_done", busy, 1);
    @(negedge clk);
    chk("t1_busy_after_done", {busy, done}, 2'b00);
    repeat (3) @(negedge clk);
    chk("t1_done_pulses", done_cnt - d0, 1);
    chk("t1_res_count", got_q.size(), 3);
    chk("t1_res0", got_q[0], 16'h3F81);
    chk("t1_res1", got_q[1], 16'h4001);
    chk("t1_res2", got_q[2], 16'h4041);
    @(posedge clk); #1;

    // T2: zero-length job
    saw_ev_in = 0; saw_op_ready = 0; d0 = done_cnt;
    start_job(0);
    wait_done(10, lat);
    chk("t2_done_latency", lat + 1, 2);
    repeat (4) @(negedge clk);
    chk("t2_no_ev_in", saw_ev_in, 0);
    chk("t2_no_op_ready", saw_op_ready, 0);
    chk("t2_done_pulses", done_cnt - d0, 1);
    @(posedge clk); #1;

    // T3: results back-pressured, credit stops issue at DEPTH buffered
    res_ready = 1'b0; got_q.delete(); p0 = pop_cnt; d0 = done_cnt;
    for (int i = 0; i < 8; i++) host_q.push_back(16'h4100 + 16'(i));
    start_job(8);
    repeat (60) @(negedge clk);
    chk("t3_issued_stalled", iss_cnt, 4);
    chk("t3_returned_stalled", ret_cnt, 4);
    chk("t3_accepted", acc_cnt, 8);
    chk("t3_ev_in_blocked", {ev_in_valid, res_valid, busy}, 3'b011);
    @(posedge clk); #1 res_ready = 1'b1;
    wait_done(300, lat);
    repeat (10) @(negedge clk);
    chk("t3_delivered", pop_cnt - p0, 8);
    chk("t3_res_first", got_q[0], 16'h4101);
    chk("t3_res_last", got_q[7], 16'h4108);
    chk("t3_done_pulses", done_cnt - d0, 1);
    @(posedge clk); #1;

    // T4: surplus operands refused, job_start during the job ignored
    d0 = done_cnt;
    for (int i = 0; i < 5; i++) host_q.push_back(16'h4200 + 16'(i));
    start_job(2);
    repeat (3) @(posedge clk);
    #1 job_start = 1'b1; job_len = 16'd7;
    @(posedge clk); #1 job_start = 1'b0;
    wait_done(200, lat);
    repeat (20) @(negedge clk);
    chk("t4_accepted", acc_cnt, 2);
    chk("t4_left_over", host_q.size(), 3);
    chk("t4_idle", {busy, op_ready}, 2'b00);
    chk("t4_done_pulses", done_cnt - d0, 1);
    @(posedge clk); #1 host_q.delete();
    @(posedge clk); #1;

    // T5: reset while draining with one request outstanding
    ev_lat = 20;
    host_q.push_back(16'h4300);
    start_job(1);
    repeat (8) @(negedge clk);
    chk("t5_in_drain", {busy, ev_in_valid, iss_cnt[1:0]}, 4'b1001);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("t5_reset_outputs", {busy, done, err, res_valid, ev_in_valid, op_ready, ev_out_ready}, 0);
    rst = 1'b0; ev_lat = 4; got_q.delete(); d0 = done_cnt;
    host_q.push_back(16'h4400);
    @(posedge clk); #1;
    start_job(1);
    wait_done(200, lat);
    repeat (3) @(negedge clk);
    chk("t5_res_count", got_q.size(), 1);
    chk("t5_res0", got_q[0], 16'h4401);
    chk("t5_done_pulses", done_cnt - d0, 1);
    @(posedge clk); #1;

`ifdef CHEBY_REQ_TIMEOUT_EN
    // T6: silent evaluator trips the watchdog
    ev_mute = 1; d0 = done_cnt;
    host_q.push_back(16'h4500);
    start_job(1);
    wait_done(100, lat);
    chk("t6_err_at_done", err, 1);
    chk("t6_tmo_latency", ((ncyc - last_iss_cyc) >= TMO) && ((ncyc - last_iss_cyc) <= TMO + 1), 1);
    @(posedge clk); #1 ev_flush = 1;
    @(posedge clk); #1 ev_flush = 0; ev_mute = 0; iss_q.delete(); res_q.delete();
    chk("t6_err_sticky", {err, busy}, 2'b10);
    chk("t6_done_pulses", done_cnt - d0, 1);
    start_job(0);
    chk("t6_err_cleared", err, 0);
    wait_done(10, lat);
    @(posedge clk); #1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
